seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot (1 kHz at 100 MHz); legal minimum 16.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period (2 Hz blink at 100 MHz).
REQ-003 SHALL have port clk, input, 1: single system clock, 100 MHz; all logic in this one clock domain.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port score, input, 10: binary game score, 0..1023.
REQ-006 SHALL have port paused, input, 1: level; 1 = game paused, display blinks.
REQ-007 SHALL have port an, output, 4: digit anodes, active-low; an[0] = units digit.
REQ-008 SHALL have port seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 SHALL run a free-running scan counter 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-010 SHALL drive exactly one an bit low per slot (an[idx]=0) unless the slot is blanked; all an bits high when blanked.
REQ-011 SHALL drive seg with the 7-seg pattern of the BCD digit held in the display register at idx (0=7'b1000000 ... 9=7'b0010000).
REQ-012 SHALL start a conversion when idx wraps 3->0 (scan-counter wrap with idx==3), snapshotting score in that cycle.
REQ-013 Conversion FSM SHALL have states IDLE, SHIFT, COMMIT: IDLE->SHIFT on start (load snapshot, clear BCD); SHIFT runs exactly 10 iterations of add-3-then-shift double-dabble; COMMIT copies the 16-bit BCD to the display register for one cycle, then returns to IDLE.
REQ-014 Latency SHALL be 12 cycles, start to display-register update; score changes during SHIFT SHALL be ignored until the next start.
REQ-015 A start while not IDLE SHALL NOT occur for legal SCAN_DIV; the FSM SHALL ignore it if it does.
REQ-016 SHALL blank leading zeros: digit k (k=3,2,1) blanked when it and all higher digits are 0; units digit never blanked (score 0 shows "0").
REQ-017 SHALL run a free-running blink counter 0..BLINK_DIV-1 toggling blink phase on wrap; when paused=1 and phase=off, all digits blanked.
REQ-018 SHALL respond to paused deassertion on the next clock edge (display unblanked regardless of phase); blink counter not reset by paused.
REQ-019 an and seg SHALL be registered outputs; a change of idx/display register/blank appears one cycle later.
REQ-020 Maximum value 1023 SHALL display as "1023" with no saturation or wrap.

Reset
REQ-021 While rst=1: an=4'b1111, seg=7'b1111111, idx=0, scan and blink counters 0, blink phase=on, FSM=IDLE, display register 0.
REQ-022 rst asserted mid-conversion SHALL abort it; the first conversion after release starts at the first 3->0 wrap.
REQ-023 From rst release until first COMMIT, display SHALL show "0" on the units digit (register 0, leading blanking).

Structure
REQ-024 Shared package snake_pkg SHALL hold SEG_BLANK (7'b1111111), AN_OFF (4'b1111), the 10-entry digit-to-segment table and BCD width constants.
REQ-025 Double-dabble iterator SHALL be sub-module bin2bcd (start, bin[9:0] in; busy, done, bcd[15:0] out); scan, blank and blink logic stays in seg_scan_ctrl.

Verification (SCAN_DIV=16, BLINK_DIV=64)
REQ-026 Reset: rst=1 for 5 cycles -> an=1111, seg=1111111; after release, units slot shows seg=1000000, an cycles 1110,1101,1011,0111 each 16 cycles with others blanked.
REQ-027 score=1023 -> after first wrap +12 cycles, slots show 1,0,2,3 (seg 1111001,1000000,0100100,0110000).
REQ-028 score=7, then 42 during SHIFT -> "7" until next conversion, then "42"; an[3:2] stay high.
REQ-029 paused=1 -> all an high for 64 of every 128 cycles; paused=0 in off phase -> active an low next cycle.
REQ-030 rst pulsed 3 cycles mid-SHIFT with score=512 -> outputs at reset values; next conversion completes to "512".
REQ-031 score=0 -> only an[0] ever low; seg=1000000.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the score display: segment encodings, anode idle value
// and binary/BCD widths used by the scan controller and its converter.
package snake_pkg;

  localparam int BIN_W      = 10;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the least significant element.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one add-3-then-shift step per cycle,
// followed by a single COMMIT cycle in which bcd holds the finished result.
module bin2bcd
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  logic [1:0]       state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       iter;

  // NOTE: default assignment first so no path leaves bcd_adj unassigned (no latch).
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      iter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SHIFT;
            bin_sr <= bin;
            bcd_sr <= '0;
            iter   <= '0;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          iter             <= iter + 4'd1;
          if (iter == LAST_ITER)
            state <= COMMIT;
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == COMMIT);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment driver for the game score: scans digits,
// refreshes the BCD display once per scan frame, blanks leading zeros and blinks when paused.
module seg_scan_ctrl
  import snake_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] score,
  input  logic       paused,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               blink_on;
  logic               scan_wrap;
  logic               blink_wrap;

  logic               conv_start;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic [BCD_W-1:0]   disp;

  logic [3:0]         lead_blank;
  logic               blank;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // A new frame's conversion starts as the scan returns to the units digit.
  assign conv_start = scan_wrap && (idx == 2'd3) && !conv_busy;

  bin2bcd u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .bin  (score),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // A digit is a leading zero when it and every higher digit are zero.
  assign lead_blank[3] = (disp[15:12] == 4'd0);
  assign lead_blank[2] = lead_blank[3] && (disp[11:8] == 4'd0);
  assign lead_blank[1] = lead_blank[2] && (disp[7:4] == 4'd0);
  assign lead_blank[0] = 1'b0;

  assign blank    = lead_blank[idx] || (paused && !blink_on);
  assign an_next  = blank ? AN_OFF : ~(4'b0001 << idx);
  assign seg_next = blank ? SEG_BLANK : digit_to_seg(disp[{idx, 2'b00} +: 4]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      blink_on  <= 1'b1;
      disp      <= '0;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (scan_wrap)
        idx <= idx + 2'd1;
      if (blink_wrap)
        blink_on <= !blink_on;
      if (conv_done)
        disp <= conv_bcd;
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=16, BLINK_DIV=64: a vector table
// of scores with hand-decoded digit patterns plus latency, pause and reset sequences.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] score;
  logic       paused;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct packed {
    logic [9:0]      score;
    logic [3:0][6:0] segs;   // expected pattern for slot 3..0, SB = blanked
  } vec_t;

  vec_t vecs [7];

  seg_scan_ctrl #(
    .SCAN_DIV (16),
    .BLINK_DIV(64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .score (score),
    .paused(paused),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    if (an !== exp_an || seg !== exp_seg) begin
      errors++;
      $display("FAIL %s (cycle %0d): an=%b seg=%b, expected an=%b seg=%b",
               name, cyc, an, seg, exp_an, exp_seg);
    end
  endtask

  // Advance one clock; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) tick();
  endtask

  function automatic logic [3:0] an_for(input int s, input logic [6:0] p);
    return (p == SB) ? 4'hF : 4'(~(4'b0001 << s));
  endfunction

  // Present a score ahead of the next frame start, then inspect all four slots
  // during the following frame once the new value is on display.
  task automatic check_vec(input vec_t v);
    int n;
    int s;
    score = v.score;
    n = (cyc / 64 + 1) * 64;
    for (int k = 1; k <= 4; k++) begin
      s = k % 4;
      wait_edge(n + 16 * k + 8);
      check($sformatf("score%0d_slot%0d", v.score, s), an_for(s, v.segs[s]), v.segs[s]);
    end
  endtask

  initial begin
    int n;
    int base;
    int blank_cnt;

    vecs[0] = '{score: 10'd0,    segs: {SB, SB, SB, S0}};
    vecs[1] = '{score: 10'd7,    segs: {SB, SB, SB, S7}};
    vecs[2] = '{score: 10'd42,   segs: {SB, SB, S4, S2}};
    vecs[3] = '{score: 10'd100,  segs: {SB, S1, S0, S0}};
    vecs[4] = '{score: 10'd512,  segs: {SB, S5, S1, S2}};
    vecs[5] = '{score: 10'd999,  segs: {SB, S9, S9, S9}};
    vecs[6] = '{score: 10'd1023, segs: {S1, S0, S2, S3}};

    // Reset held for 5 cycles.
    rst    = 1'b1;
    score  = 10'd0;
    paused = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_early", 4'hF, SB);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 4'hF, SB);
    rst = 1'b0;
    cyc = 0;

    // Display register is zero: only the units digit shows "0".
    wait_edge(8);  check("por_slot0", 4'b1110, S0);
    wait_edge(24); check("por_slot1", 4'hF, SB);
    wait_edge(40); check("por_slot2", 4'hF, SB);
    wait_edge(56); check("por_slot3", 4'hF, SB);

    // Frame start at edge 64 snapshots 7; 42 arrives mid-conversion and must wait.
    score = 10'd7;
    wait_edge(67);
    score = 10'd42;
    wait_edge(75);  check("latency_old", 4'b1110, S0);
    wait_edge(76);  check("latency_new", 4'b1110, S7);
    wait_edge(88);  check("seven_slot1", 4'hF, SB);
    wait_edge(104); check("seven_slot2", 4'hF, SB);
    wait_edge(120); check("seven_slot3", 4'hF, SB);
    wait_edge(144); check("fortytwo_slot0", 4'b1110, S2);
    wait_edge(152); check("fortytwo_slot1", 4'b1101, S4);
    wait_edge(168); check("fortytwo_slot2", 4'hF, SB);
    wait_edge(184); check("fortytwo_slot3", 4'hF, SB);

    for (int i = 0; i < 7; i++) check_vec(vecs[i]);

    // Pause with 1023 shown: blink phase is off for edges 128j+65..128j+128.
    paused = 1'b1;
    base = (cyc / 128 + 1) * 128;
    wait_edge(base + 64);
    blank_cnt = 0;
    for (int k = base + 65; k <= base + 192; k++) begin
      wait_edge(k);
      if (an == 4'hF) blank_cnt++;
      if (k == base + 72)  check("pause_off_phase", 4'hF, SB);
      if (k == base + 136) check("pause_on_phase", 4'b1110, S3);
    end
    checks++;
    if (blank_cnt != 64) begin
      errors++;
      $display("FAIL pause_blank_count: %0d blanked cycles, expected 64", blank_cnt);
    end
    wait_edge(base + 200);
    check("pause_off_again", 4'hF, SB);
    paused = 1'b0;
    tick();
    check("unpause_next_edge", 4'b1110, S3);

    // Reset pulse in the middle of a conversion of 512.
    score = 10'd512;
    n = (cyc / 64 + 1) * 64;
    wait_edge(n + 4);
    rst = 1'b1;
    #1;
    check("rst_mid_async", 4'hF, SB);
    repeat (3) tick();
    check("rst_mid_hold", 4'hF, SB);
    rst = 1'b0;
    cyc = 0;
    wait_edge(72); check("rst_mid_zero", 4'b1110, S0);
    wait_edge(80); check("rst_mid_first", 4'b1110, S2);
    check_vec(vecs[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
